// File: rtl/nibble_serial_addsub_if.sv
// Operand/result handshake bundle for the nibble-serial add/sub unit.
// master = operand source and result consumer, slave = the arithmetic unit.
interface nibble_serial_addsub_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] RESULT;
    logic             Cout;
    logic             OVF;

    modport master (
        output in_valid, op_sub, A, B, out_ready,
        input  in_ready, out_valid, RESULT, Cout, OVF
    );

    modport slave (
        input  in_valid, op_sub, A, B, out_ready,
        output in_ready, out_valid, RESULT, Cout, OVF
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract: one 4-bit ripple-carry slice per clock, LSB first,
// with a registered carry between slices. Subtract runs as A + ~B + 1.
module nibble_serial_addsub #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nibble_serial_addsub_if.slave   bus
);
    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             sub_lat;
    logic             c;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             in_ready;
    logic             out_valid;

    logic [IDXW+1:0]  base;
    logic [3:0]       a_nib;
    logic [3:0]       b_eff;
    logic [3:0]       sum_c;
    logic             cout_c;
    logic             carry;

    // Current slice operands and the 4-bit ripple-carry core
    always_comb begin
        base   = {idx, 2'b00};
        a_nib  = a_lat[base +: 4];
        b_eff  = b_lat[base +: 4] ^ {4{sub_lat}};
        sum_c  = '0;
        carry  = c;
        for (int i = 0; i < 4; i++) begin
            sum_c[i] = a_nib[i] ^ b_eff[i] ^ carry;
            carry    = (a_nib[i] & b_eff[i]) | (carry & (a_nib[i] ^ b_eff[i]));
        end
        cout_c = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_lat     <= '0;
            b_lat     <= '0;
            sub_lat   <= 1'b0;
            c         <= 1'b0;
            idx       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_lat    <= bus.A;
                        b_lat    <= bus.B;
                        sub_lat  <= bus.op_sub;
                        c        <= bus.op_sub;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result[base +: 4] <= sum_c;
                    c                 <= cout_c;
                    idx               <= idx + 1'b1;
                    if (idx == LAST) begin
                        // Overflow judged on the effective (already inverted) top-slice inputs
                        cout      <= cout_c;
                        ovf       <= (a_nib[3] == b_eff[3]) && (sum_c[3] != a_nib[3]);
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.RESULT    = result;
    assign bus.Cout      = cout;
    assign bus.OVF       = ovf;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub (NIBBLES=4): directed table, corner-case sequences and
// random operands checked against an integer-arithmetic reference model.
module tb_nibble_serial_addsub;
    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_serial_addsub_if #(.NIBBLES(NIBBLES)) bus();
    nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] r;
        logic         co;
        logic         ov;
    } res_t;

    typedef struct {
        string        nm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];
    res_t exp_q[$];
    bit   collect = 1'b0;
    res_t got_e;

    // Reference: plain integer add/sub, carry from the unsigned range, overflow from the signed range
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        res_t   m;
        longint span = longint'(1) << W;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = a[W-1] ? ua - span : ua;
        longint sb   = b[W-1] ? ub - span : ub;
        longint ur;
        longint sr;
        if (s) begin
            ur   = ua - ub;
            sr   = sa - sb;
            m.co = (ua >= ub);
        end else begin
            ur   = ua + ub;
            sr   = sa + sb;
            m.co = (ur >= span);
        end
        m.r  = W'(ur);
        m.ov = (sr >= span / 2) || (sr < -(span / 2));
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // One complete operation with out_ready high; checks latency, outputs and return to IDLE
    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] er, input logic eco, input logic eov);
        int g;
        int lat;
        @(negedge clk);
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.A = a; bus.B = b; bus.op_sub = s; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 32'(lat), 32'(NIBBLES));
        chk({nm, " RESULT"}, 32'(bus.RESULT), 32'(er));
        chk({nm, " Cout"}, 32'(bus.Cout), 32'(eco));
        chk({nm, " OVF"}, 32'(bus.OVF), 32'(eov));
        @(posedge clk);
        @(negedge clk);
        chk({nm, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        chk({nm, " in_ready back"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Back-to-back phase: results retire in acceptance order
    always @(negedge clk) begin
        if (collect && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("b2b unexpected result", 32'd1, 32'd0);
            end else begin
                got_e = exp_q.pop_front();
                chk("b2b RESULT", 32'(bus.RESULT), 32'(got_e.r));
                chk("b2b Cout", 32'(bus.Cout), 32'(got_e.co));
                chk("b2b OVF", 32'(bus.OVF), 32'(got_e.ov));
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        res_t         m;
        int           g;
        bit           seen;

        tbl.push_back('{"add 1234+0FFF", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0});
        tbl.push_back('{"sub 3-2",       16'h0003, 16'h0002, 1'b1, 16'h0001, 1'b1, 1'b0});
        tbl.push_back('{"sub 1-2",       16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0});
        tbl.push_back('{"add FFFF+1",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{"add 7FFF+1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
        tbl.push_back('{"sub 8000-1",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1});
        tbl.push_back('{"sub 0-0",       16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{"add 8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.op_sub = 1'b0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b0;
        #12;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset RESULT", 32'(bus.RESULT), 32'd0);
        chk("reset Cout", 32'(bus.Cout), 32'd0);
        chk("reset OVF", 32'(bus.OVF), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);

        foreach (tbl[i])
            do_op(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].r, tbl[i].co, tbl[i].ov);

        // Backpressure, with an in_valid pulse during RUN that must be ignored
        @(negedge clk);
        bus.A = 16'h1111; bus.B = 16'h2222; bus.op_sub = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.op_sub = 1'b1; bus.in_valid = 1'b1;
        chk("bp in_ready in RUN", 32'(bus.in_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        g = 0;
        while (!bus.out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp RESULT", 32'(bus.RESULT), 32'h3333);
            chk("bp Cout", 32'(bus.Cout), 32'd0);
            chk("bp OVF", 32'(bus.OVF), 32'd0);
            chk("bp in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("bp no ghost op", 32'(seen), 32'd0);

        // Reset after two nibbles have been processed
        bus.A = 16'h1234; bus.B = 16'h1111; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun RESULT", 32'(bus.RESULT), 32'd0);
        chk("midrun Cout", 32'(bus.Cout), 32'd0);
        chk("midrun OVF", 32'(bus.OVF), 32'd0);
        chk("midrun out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrun in_ready", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("midrun dropped", 32'(seen), 32'd0);
        do_op("sub A-5 after reset", 16'h000A, 16'h0005, 1'b1, 16'h0005, 1'b1, 1'b0);

        // Random single operations against the model
        for (int k = 0; k < 12; k++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            m  = model(ra, rb, rs);
            do_op("rand", ra, rb, rs, m.r, m.co, m.ov);
        end

        // Back-to-back with in_valid held high; operands change every acceptance
        collect = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            bus.A = ra; bus.B = rb; bus.op_sub = rs; bus.in_valid = 1'b1;
            g = 0;
            while (!bus.in_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            chk("b2b accept wait", 32'(bus.in_ready), 32'd1);
            exp_q.push_back(model(ra, rb, rs));
            @(posedge clk); @(negedge clk);
            chk("b2b busy after accept", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        chk("b2b drained", 32'(exp_q.size()), 32'd0);
        collect = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
